// File: rtl/timer_lease_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_lease_pkg
// Purpose  : Shared types and constants for the timer lease scheduler:
//            FSM state encoding, Avalon interval-timer register word
//            addresses and the control words written to the timer.
// Revision : 1.0 - initial release
// ============================================================================
package timer_lease_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_STOP  = 4'd1,
        WR_PL    = 4'd2,
        WR_PH    = 4'd3,
        GAP      = 4'd4,
        WR_START = 4'd5,
        WAIT_IRQ = 4'd6,
        CANCEL   = 4'd7,
        CLR_ST   = 4'd8,
        FIN      = 4'd9
    } state_t;

    // Interval timer word addresses
    localparam logic [2:0] STATUS  = 3'd0;
    localparam logic [2:0] CONTROL = 3'd1;
    localparam logic [2:0] PERIODL = 3'd2;
    localparam logic [2:0] PERIODH = 3'd3;

    // STOP=bit3; START=bit2, ITO=bit0, CONT=bit1 left clear (one-shot)
    localparam logic [15:0] CTRL_STOP              = 16'h0008;
    localparam logic [15:0] CTRL_START_ONESHOT_IRQ = 16'h0005;

endpackage : timer_lease_pkg
`default_nettype wire

// File: rtl/timer_lease_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : timer_lease_sched_if
// Purpose  : Avalon-MM bus toward the interval timer slave (16-bit data,
//            3-bit word address, no waitrequest) plus its level interrupt.
// Ports    : tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata
//            (master -> timer), tmr_irq (timer -> master).
//            modport master : the lease scheduler
//            modport slave  : the timer
// Revision : 1.0 - initial release
// ============================================================================
interface timer_lease_sched_if;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic        tmr_irq;

    modport master (
        output tmr_address,
        output tmr_chipselect,
        output tmr_write_n,
        output tmr_writedata,
        input  tmr_irq
    );

    modport slave (
        input  tmr_address,
        input  tmr_chipselect,
        input  tmr_write_n,
        input  tmr_writedata,
        output tmr_irq
    );
endinterface : timer_lease_sched_if
`default_nettype wire

// File: rtl/timer_lease_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick. Searches req starting at index
//            ptr upward, wrapping at N, and returns the first set index.
// Ports    : req       in  N  request vector
//            ptr       in  W  search start index (always < N)
//            grant_idx out W  winning index (0 when nothing requested)
//            valid     out 1  at least one request present
// Revision : 1.0 - initial release
// ============================================================================
import timer_lease_pkg::*;

module rr_arbiter #(
    parameter int N = 4,
    parameter int W = ($clog2(N) > 0 ? $clog2(N) : 1)
) (
    input  wire logic [N-1:0] req,
    input  wire logic [W-1:0] ptr,
    output logic      [W-1:0] grant_idx,
    output logic              valid
);

    int w_idx;

    always_comb begin
        grant_idx = '0;
        valid     = 1'b0;
        w_idx     = 0;
        for (int i = 0; i < N; i++) begin
            // ptr < N, so one conditional subtraction wraps the index
            w_idx = int'(ptr) + i;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!valid && req[w_idx]) begin
                valid     = 1'b1;
                grant_idx = W'(w_idx);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/timer_lease_sched.sv
`default_nettype none
// ============================================================================
// Module   : timer_lease_sched
// Purpose  : Leases a single Avalon-MM interval timer to N_REQ one-shot
//            timeout requesters. Round-robin grant, programs the winner's
//            32-bit period, starts the timer one-shot with irq enabled,
//            waits for irq (or cancel), clears status, pulses done.
// Ports    : clk, reset_n (async, active-low)
//            req[N_REQ]          level requests (drop to cancel)
//            req_period[32*N]    per-requester period, sampled at grant
//            done[N_REQ]         one-cycle completion pulse
//            busy                high whenever not IDLE
//            grant_id[IDW]       current/last lease index
//            tmr                 timer bus (master modport)
// Options  : `define TIMER_LEASE_CLAMP_EN to floor periods at MIN_PERIOD.
// Revision : 1.0 - initial release
// ============================================================================
import timer_lease_pkg::*;

module timer_lease_sched #(
    parameter int          N_REQ      = 4,
    parameter int          IDW        = ($clog2(N_REQ) > 0 ? $clog2(N_REQ) : 1),
    parameter logic [31:0] MIN_PERIOD = 32'd16
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    input  wire logic [N_REQ-1:0]     req,
    input  wire logic [32*N_REQ-1:0]  req_period,
    output logic      [N_REQ-1:0]     done,
    output logic                      busy,
    output logic      [IDW-1:0]       grant_id,
    timer_lease_sched_if.master       tmr
);

`ifdef TIMER_LEASE_CLAMP_EN
    localparam bit c_clamp_en = 1'b1;
`else
    localparam bit c_clamp_en = 1'b0;
`endif

    // With clamping off the floor is 0, and max(x, 0) == x
    localparam logic [31:0] c_floor = MIN_PERIOD & {32{c_clamp_en}};

    state_t         r_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [31:0]    r_period;
    logic           r_pend;

    logic [IDW-1:0] w_win;
    logic           w_win_vld;
    logic [31:0]    w_raw_period;
    logic [31:0]    w_period_sel;

    rr_arbiter #(
        .N (N_REQ),
        .W (IDW)
    ) u_arb (
        .req       (req),
        .ptr       (r_rr_ptr),
        .grant_idx (w_win),
        .valid     (w_win_vld)
    );

    assign w_raw_period = req_period[32*w_win +: 32];
    assign w_period_sel = (w_raw_period <= c_floor) ? c_floor : w_raw_period;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state            <= IDLE;
            r_rr_ptr           <= '0;
            r_period           <= '0;
            r_pend             <= 1'b0;
            done               <= '0;
            busy               <= 1'b0;
            grant_id           <= '0;
            tmr.tmr_address    <= '0;
            tmr.tmr_chipselect <= 1'b0;
            tmr.tmr_write_n    <= 1'b1;
            tmr.tmr_writedata  <= '0;
        end else begin
            // Strobes default off so every write lasts exactly one cycle
            done               <= '0;
            tmr.tmr_chipselect <= 1'b0;
            tmr.tmr_write_n    <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_win_vld) begin
                        grant_id <= w_win;
                        r_period <= w_period_sel;
                        r_rr_ptr <= (w_win == IDW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
                        busy     <= 1'b1;
                        r_state  <= WR_STOP;
                    end
                end
                WR_STOP: begin
                    tmr.tmr_chipselect <= 1'b1;
                    tmr.tmr_write_n    <= 1'b0;
                    tmr.tmr_address    <= CONTROL;
                    tmr.tmr_writedata  <= CTRL_STOP;
                    r_state            <= WR_PL;
                end
                WR_PL: begin
                    tmr.tmr_chipselect <= 1'b1;
                    tmr.tmr_write_n    <= 1'b0;
                    tmr.tmr_address    <= PERIODL;
                    tmr.tmr_writedata  <= r_period[15:0];
                    r_state            <= WR_PH;
                end
                WR_PH: begin
                    tmr.tmr_chipselect <= 1'b1;
                    tmr.tmr_write_n    <= 1'b0;
                    tmr.tmr_address    <= PERIODH;
                    tmr.tmr_writedata  <= r_period[31:16];
                    r_state            <= GAP;
                end
                GAP: begin
                    // Idle bus cycle lets the timer finish its period reload
                    // before the start command lands
                    r_state <= WR_START;
                end
                WR_START: begin
                    tmr.tmr_chipselect <= 1'b1;
                    tmr.tmr_write_n    <= 1'b0;
                    tmr.tmr_address    <= CONTROL;
                    tmr.tmr_writedata  <= CTRL_START_ONESHOT_IRQ;
                    r_state            <= WAIT_IRQ;
                end
                WAIT_IRQ: begin
                    // irq has priority: a timeout that fires together with a
                    // cancel is still reported
                    if (tmr.tmr_irq) begin
                        r_pend  <= 1'b1;
                        r_state <= CLR_ST;
                    end else if (!req[grant_id]) begin
                        r_state <= CANCEL;
                    end
                end
                CANCEL: begin
                    tmr.tmr_chipselect <= 1'b1;
                    tmr.tmr_write_n    <= 1'b0;
                    tmr.tmr_address    <= CONTROL;
                    tmr.tmr_writedata  <= CTRL_STOP;
                    r_pend             <= 1'b0;
                    r_state            <= CLR_ST;
                end
                CLR_ST: begin
                    tmr.tmr_chipselect <= 1'b1;
                    tmr.tmr_write_n    <= 1'b0;
                    tmr.tmr_address    <= STATUS;
                    tmr.tmr_writedata  <= 16'h0000;
                    r_state            <= FIN;
                end
                FIN: begin
                    done[grant_id] <= r_pend;
                    busy           <= 1'b0;
                    r_state        <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : timer_lease_sched
`default_nettype wire

// File: tb/tb_timer_lease_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_lease_sched
// Purpose  : Self-checking bench for timer_lease_sched with a behavioural
//            interval-timer model. Table of lease vectors plus hand-written
//            irq/cancel race and mid-lease reset sequences.
// Options  : honours TIMER_LEASE_CLAMP_EN for the expected period writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_lease_sched;

`ifdef TIMER_LEASE_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   req     = '0;
    logic [127:0] req_period = '0;
    logic [3:0]   done;
    logic         busy;
    logic [1:0]   grant_id;

    timer_lease_sched_if bus ();

    timer_lease_sched #(
        .N_REQ      (4),
        .IDW        (2),
        .MIN_PERIOD (32'd16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_period (req_period),
        .done       (done),
        .busy       (busy),
        .grant_id   (grant_id),
        .tmr        (bus)
    );

    always #5 clk = ~clk;

    // ---------------- interval timer model ----------------
    logic [31:0] m_period = '0;
    logic [31:0] m_cnt    = '0;
    logic        m_run    = 1'b0;
    logic        m_irq    = 1'b0;
    logic        manual_mode = 1'b0;
    logic        manual_irq  = 1'b0;

    assign bus.tmr_irq = manual_mode ? manual_irq : m_irq;

    always @(posedge clk) begin
        if (bus.tmr_chipselect && !bus.tmr_write_n) begin
            case (bus.tmr_address)
                3'd0: m_irq <= 1'b0;
                3'd1: begin
                    if (bus.tmr_writedata[3]) begin
                        m_run <= 1'b0;
                    end else if (bus.tmr_writedata[2]) begin
                        m_run <= 1'b1;
                        m_cnt <= m_period;
                    end
                end
                3'd2: m_period[15:0]  <= bus.tmr_writedata;
                3'd3: m_period[31:16] <= bus.tmr_writedata;
                default: ;
            endcase
        end else if (m_run) begin
            if (m_cnt == 32'd0) begin
                m_irq <= 1'b1;
                m_run <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 32'd1;
            end
        end
    end

    // ---------------- sampling and checking ----------------
    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
        int          cyc;
    } wr_t;

    wr_t        wq[$];
    int         cyc      = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic [3:0] done_acc = '0;
    int         checks   = 0;
    int         errors   = 0;

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.tmr_chipselect && !bus.tmr_write_n)
            wq.push_back('{a: bus.tmr_address, d: bus.tmr_writedata, cyc: cyc});
        if (done != 4'b0) begin
            done_cnt++;
            done_acc = done_acc | done;
            done_cyc = cyc;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event within bound", nm);
    endtask

    task automatic clear_obs();
        wq.delete();
        done_cnt = 0;
        done_acc = '0;
        done_cyc = 0;
    endtask

    task automatic wait_writes(input int n, input string nm);
        int k = 0;
        while (wq.size() < n && k < 50) begin
            tick();
            k++;
        end
        if (wq.size() < n) tmo(nm);
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy && k < 70000) begin
            tick();
            k++;
        end
        if (busy) tmo(nm);
    endtask

    // One full lease, entered with the DUT idle in the current cycle.
    task automatic run_lease(input logic [3:0] r, input logic [31:0] per, input bit cancel,
                             input logic [1:0] eg, input logic [15:0] epl, input logic [15:0] eph);
        logic [2:0]  ea[6];
        logic [15:0] ed[6];
        int          ne;
        req_period = {4{per}};
        req        = r;
        clear_obs();
        tick();
        chk("busy_rise", {31'd0, busy}, 32'd1);
        chk("grant_id", {30'd0, grant_id}, {30'd0, eg});
        // Period already latched; a later change must not reach the timer
        req_period = {4{32'hFFFF_FFFF}};
        wait_writes(4, "start_write");
        if (cancel) begin
            repeat (3) tick();
            req = r & ~(4'b0001 << eg);
        end
        wait_idle("lease_end");

        ea[0] = 3'd1; ed[0] = 16'h0008;
        ea[1] = 3'd2; ed[1] = epl;
        ea[2] = 3'd3; ed[2] = eph;
        ea[3] = 3'd1; ed[3] = 16'h0005;
        if (cancel) begin
            ea[4] = 3'd1; ed[4] = 16'h0008;
            ea[5] = 3'd0; ed[5] = 16'h0000;
            ne = 6;
        end else begin
            ea[4] = 3'd0; ed[4] = 16'h0000;
            ea[5] = 3'd0; ed[5] = 16'h0000;
            ne = 5;
        end
        chk("n_writes", wq.size(), ne);
        for (int i = 0; i < ne && i < wq.size(); i++) begin
            chk($sformatf("wr%0d_addr", i), {29'd0, wq[i].a}, {29'd0, ea[i]});
            chk($sformatf("wr%0d_data", i), {16'd0, wq[i].d}, {16'd0, ed[i]});
        end
        if (wq.size() >= 4) begin
            chk("b2b_writes", wq[2].cyc - wq[0].cyc, 32'd2);
            chk("gap_before_start", wq[3].cyc - wq[2].cyc, 32'd2);
        end
        chk("done_count", done_cnt, cancel ? 32'd0 : 32'd1);
        chk("done_value", {28'd0, done_acc}, cancel ? 32'd0 : {28'd0, 4'b0001 << eg});
        if (!cancel && wq.size() >= 4)
            chk("start_to_done", done_cyc - wq[3].cyc, {eph, epl} + 32'd5);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] per;
        bit          cancel;
        logic [1:0]  eg;
        logic [15:0] epl;
        logic [15:0] eph;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int irq_cyc;

        // round-robin with 1011 held, fresh pointer 0
        tbl[0] = '{4'b1011, 32'd5, 1'b0, 2'd0, 16'h0005, 16'h0000};
        tbl[1] = '{4'b1011, 32'd5, 1'b0, 2'd1, 16'h0005, 16'h0000};
        tbl[2] = '{4'b1011, 32'd5, 1'b0, 2'd3, 16'h0005, 16'h0000};
        tbl[3] = '{4'b1011, 32'd5, 1'b0, 2'd0, 16'h0005, 16'h0000};
        tbl[4] = '{4'b1011, 32'd5, 1'b0, 2'd1, 16'h0005, 16'h0000};
        tbl[5] = '{4'b1011, 32'd5, 1'b0, 2'd3, 16'h0005, 16'h0000};
        // single long lease
        tbl[6] = '{4'b0001, 32'h0001_0020, 1'b0, 2'd0, 16'h0020, 16'h0001};
        // cancel in WAIT_IRQ
        tbl[7] = '{4'b0100, 32'd1000, 1'b1, 2'd2, 16'h03E8, 16'h0000};
        // period 0 and period 3 (floored to 16 when clamping)
        tbl[8] = '{4'b1000, 32'd0, 1'b0, 2'd3, CLAMP ? 16'h0010 : 16'h0000, 16'h0000};
        tbl[9] = '{4'b0001, 32'd3, 1'b0, 2'd0, CLAMP ? 16'h0010 : 16'h0003, 16'h0000};

        repeat (3) tick();
        chk("rst_done", {28'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
        chk("rst_cs", {31'd0, bus.tmr_chipselect}, 32'd0);
        chk("rst_write_n", {31'd0, bus.tmr_write_n}, 32'd1);
        chk("rst_addr", {29'd0, bus.tmr_address}, 32'd0);
        chk("rst_wdata", {16'd0, bus.tmr_writedata}, 32'd0);
        reset_n = 1'b1;
        tick();

        for (int v = 0; v < 10; v++)
            run_lease(tbl[v].req, tbl[v].per, tbl[v].cancel, tbl[v].eg, tbl[v].epl, tbl[v].eph);

        // irq and cancel in the same cycle: irq wins (pointer now 1 -> grant 1)
        manual_mode = 1'b1;
        manual_irq  = 1'b0;
        req_period  = {4{32'd1000}};
        req         = 4'b0010;
        clear_obs();
        tick();
        chk("race_grant", {30'd0, grant_id}, 32'd1);
        wait_writes(4, "race_start_write");
        repeat (2) tick();
        req        = 4'b0000;
        manual_irq = 1'b1;
        irq_cyc    = cyc;
        wait_idle("race_end");
        manual_irq  = 1'b0;
        manual_mode = 1'b0;
        chk("race_n_writes", wq.size(), 32'd5);
        if (wq.size() >= 5) begin
            chk("race_last_addr", {29'd0, wq[4].a}, 32'd0);
            chk("race_last_data", {16'd0, wq[4].d}, 32'd0);
        end
        chk("race_done_count", done_cnt, 32'd1);
        chk("race_done_value", {28'd0, done_acc}, 32'h2);
        chk("race_irq_to_done", done_cyc - irq_cyc, 32'd3);

        // reset during the period-high write (pointer 2 -> search 2,3,0)
        req_period = {4{32'h0000_0040}};
        req        = 4'b0001;
        clear_obs();
        tick();
        chk("rst_lease_grant", {30'd0, grant_id}, 32'd0);
        wait_writes(3, "ph_write");
        reset_n = 1'b0;
        #1;
        chk("mid_rst_done", {28'd0, done}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_grant_id", {30'd0, grant_id}, 32'd0);
        chk("mid_rst_cs", {31'd0, bus.tmr_chipselect}, 32'd0);
        chk("mid_rst_write_n", {31'd0, bus.tmr_write_n}, 32'd1);
        chk("mid_rst_addr", {29'd0, bus.tmr_address}, 32'd0);
        chk("mid_rst_wdata", {16'd0, bus.tmr_writedata}, 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        // pointer back to 0 after reset
        run_lease(4'b0001, 32'h0000_0040, 1'b0, 2'd0, 16'h0040, 16'h0000);

        req = 4'b0000;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_timer_lease_sched
`default_nettype wire
